// File: rtl/mult_result_accum.sv
// Batch accumulator behind the 4x4 multiplier: sums BATCH products per batch and
// presents each sum on a valid/ready register. Optional saturation via MULT_ACC_SAT_EN.
module mult_result_accum #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned BATCH  = 4,
  parameter int unsigned ACC_W  = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         res_done,
  input  logic [PROD_W-1:0]            result,
  input  logic                         clear,
  output logic                         acc_valid,
  input  logic                         acc_ready,
  output logic [ACC_W-1:0]             acc_sum,
  output logic [$clog2(BATCH+1)-1:0]   batch_cnt,
  output logic                         drop_err
);

  localparam int unsigned CNT_W = $clog2(BATCH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH - 1);

  typedef enum logic {EMPTY, FILL} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_add;
  logic [ACC_W-1:0]  prod_ext;
  logic              take;
  logic              complete;
  logic              handshake;
  logic              load;

  assign prod_ext = ACC_W'(result);

`ifdef MULT_ACC_SAT_EN
  logic [ACC_W:0] acc_wide;
  // Addends are non-negative, so a saturated accumulator stays pinned until the batch closes.
  always_comb begin
    acc_wide = {1'b0, acc} + {1'b0, prod_ext};
    acc_add  = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
  end
`else
  assign acc_add = acc + prod_ext;
`endif

  // clear takes priority over a coincident product; that product is discarded.
  assign take      = res_done & ~clear;
  assign complete  = take && (batch_cnt == LAST_CNT);
  assign handshake = acc_valid & acc_ready;
  assign load      = complete && (!acc_valid || acc_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (take) state_nxt = FILL;
      FILL:  if (clear || complete) state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      acc       <= '0;
      batch_cnt <= '0;
      acc_valid <= 1'b0;
      acc_sum   <= '0;
      drop_err  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (clear || complete) begin
        acc       <= '0;
        batch_cnt <= '0;
      end else if (take) begin
        acc       <= acc_add;
        batch_cnt <= batch_cnt + CNT_W'(1);
      end

      // A completion while the output is held loses the new sum; otherwise it refills with no bubble.
      if (load) begin
        acc_sum   <= acc_add;
        acc_valid <= 1'b1;
      end else if (complete) begin
        drop_err  <= 1'b1;
      end else if (handshake) begin
        acc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_result_accum.sv
// Self-checking bench for mult_result_accum: scoreboard of expected batch sums
// popped on every output handshake, plus per-scenario directed checks.
module tb_mult_result_accum;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       res_done = 1'b0;
  logic [7:0] result = '0;
  logic       clear = 1'b0;
  logic       acc_ready = 1'b0;
  logic       acc_valid;
  logic [9:0] acc_sum;
  logic [2:0] batch_cnt;
  logic       drop_err;

  // Narrow-accumulator instance for the wrap/saturate scenario.
  logic       reset8 = 1'b1;
  logic       res_done8 = 1'b0;
  logic [7:0] result8 = '0;
  logic       acc_valid8;
  logic [7:0] acc_sum8;
  logic [2:0] batch_cnt8;
  logic       drop_err8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_result_accum #(.PROD_W(8), .BATCH(4), .ACC_W(10)) dut (
    .clk(clk), .reset(reset), .res_done(res_done), .result(result), .clear(clear),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_sum(acc_sum),
    .batch_cnt(batch_cnt), .drop_err(drop_err)
  );

  mult_result_accum #(.PROD_W(8), .BATCH(4), .ACC_W(8)) dut8 (
    .clk(clk), .reset(reset8), .res_done(res_done8), .result(result8), .clear(1'b0),
    .acc_valid(acc_valid8), .acc_ready(1'b0), .acc_sum(acc_sum8),
    .batch_cnt(batch_cnt8), .drop_err(drop_err8)
  );

  // Reference model: batches of 4 products, sums mod 1024, one-entry output register.
  int unsigned m_acc = 0;
  int unsigned m_cnt = 0;
  bit          m_valid = 1'b0;
  bit          m_drop = 1'b0;
  int unsigned sb_q[$];

  always @(posedge clk) begin
    bit hs;
    if (reset) begin
      m_acc = 0; m_cnt = 0; m_valid = 1'b0; m_drop = 1'b0;
      sb_q.delete();
    end else begin
      hs = m_valid && acc_ready;
      if (!clear && res_done && m_cnt == 3) begin
        if (!m_valid || hs) begin
          sb_q.push_back((m_acc + result) % 1024);
          m_valid = 1'b1;
        end else begin
          m_drop = 1'b1;
        end
        m_acc = 0; m_cnt = 0;
      end else begin
        if (clear) begin
          m_acc = 0; m_cnt = 0;
        end else if (res_done) begin
          m_acc = m_acc + result; m_cnt = m_cnt + 1;
        end
        if (hs) m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int unsigned exp_sum;
    checks++;
    if (acc_valid !== m_valid || batch_cnt !== 3'(m_cnt) || drop_err !== m_drop) begin
      errors++;
      $display("FAIL monitor_state t=%0t valid=%b/%b cnt=%0d/%0d drop=%b/%b (actual/required)",
               $time, acc_valid, m_valid, batch_cnt, m_cnt, drop_err, m_drop);
    end
    if (acc_valid === 1'b1 && acc_ready === 1'b1 && !reset) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_handshake t=%0t actual=%0d required=<no pending sum>", $time, acc_sum);
      end else begin
        exp_sum = sb_q.pop_front();
        if (acc_sum !== 10'(exp_sum)) begin
          errors++;
          $display("FAIL sb_handshake t=%0t actual=%0d required=%0d", $time, acc_sum, exp_sum);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [7:0] v);
    res_done = 1'b1; result = v;
    @(posedge clk); #1;
    res_done = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++;
    if (acc_valid !== 1'b0 || acc_sum !== '0 || batch_cnt !== '0 || drop_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values actual v=%b s=%0d c=%0d d=%b required all 0",
               acc_valid, acc_sum, batch_cnt, drop_err);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_batch();
    logic [7:0] prods [4] = '{8'd3, 8'd5, 8'd7, 8'd9};
    acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(prods[i]);
      if (i == 0) begin
        checks++;
        if (batch_cnt !== 3'd1) begin
          errors++;
          $display("FAIL batch_cnt_first actual=%0d required=1", batch_cnt);
        end
      end
      if (i < 3) idle($urandom_range(4, 10));
    end
    checks++;
    if (acc_valid !== 1'b1 || acc_sum !== 10'd24 || batch_cnt !== 3'd0) begin
      errors++;
      $display("FAIL batch_sum actual v=%b s=%0d c=%0d required v=1 s=24 c=0",
               acc_valid, acc_sum, batch_cnt);
    end
    idle(1);
    checks++;
    if (acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL batch_drain actual=%b required=0", acc_valid);
    end
    idle(2);
  endtask

  task automatic test_drop();
    acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin send(8'd1); idle(1); end
    checks++;
    if (acc_valid !== 1'b1 || acc_sum !== 10'd4 || drop_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_first actual v=%b s=%0d d=%b required v=1 s=4 d=0",
               acc_valid, acc_sum, drop_err);
    end
    for (int i = 0; i < 4; i++) begin send(8'd2); idle(1); end
    checks++;
    if (acc_valid !== 1'b1 || acc_sum !== 10'd4 || drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_held actual v=%b s=%0d d=%b required v=1 s=4 d=1",
               acc_valid, acc_sum, drop_err);
    end
    acc_ready = 1'b1;
    idle(1);
    checks++;
    if (acc_valid !== 1'b0 || drop_err !== 1'b1 || acc_sum !== 10'd4) begin
      errors++;
      $display("FAIL drop_release actual v=%b d=%b s=%0d required v=0 d=1 s=4",
               acc_valid, drop_err, acc_sum);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    acc_ready = 1'b0;
    pulse_reset();
    for (int i = 0; i < 4; i++) send(8'd1);
    for (int i = 0; i < 3; i++) begin send(8'd10); idle(2); end
    acc_ready = 1'b1;
    send(8'd10);
    acc_ready = 1'b0;
    checks++;
    if (acc_valid !== 1'b1 || acc_sum !== 10'd40 || drop_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load actual v=%b s=%0d d=%b required v=1 s=40 d=0",
               acc_valid, acc_sum, drop_err);
    end
    idle(2);
    acc_ready = 1'b1;
    idle(1);
    checks++;
    if (acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain actual=%b required=0", acc_valid);
    end
  endtask

  task automatic test_clear();
    acc_ready = 1'b1;
    send(8'd15); send(8'd15);
    checks++;
    if (batch_cnt !== 3'd2) begin
      errors++;
      $display("FAIL clear_pre_cnt actual=%0d required=2", batch_cnt);
    end
    clear = 1'b1;
    send(8'd99);
    clear = 1'b0;
    checks++;
    if (batch_cnt !== 3'd0 || acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_flush actual c=%0d v=%b required c=0 v=0", batch_cnt, acc_valid);
    end
    acc_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i));
    checks++;
    if (acc_valid !== 1'b1 || acc_sum !== 10'd10) begin
      errors++;
      $display("FAIL clear_sum actual v=%b s=%0d required v=1 s=10", acc_valid, acc_sum);
    end
    acc_ready = 1'b1;
    idle(1);
    acc_ready = 1'b0;
    send(8'd7); send(8'd7);
    pulse_reset();
    checks++;
    if (batch_cnt !== 3'd0 || acc_valid !== 1'b0 || acc_sum !== '0) begin
      errors++;
      $display("FAIL reset_mid_batch actual c=%0d v=%b s=%0d required c=0 v=0 s=0",
               batch_cnt, acc_valid, acc_sum);
    end
    send(8'd5); send(8'd5);
    idle(3);
    checks++;
    if (batch_cnt !== 3'd2 || acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart actual c=%0d v=%b required c=2 v=0", batch_cnt, acc_valid);
    end
    pulse_reset();
  endtask

  task automatic test_wrap();
    logic [7:0] exp8;
`ifdef MULT_ACC_SAT_EN
    exp8 = 8'd255;
`else
    exp8 = 8'd132;
`endif
    reset8 = 1'b1;
    idle(2);
    reset8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      res_done8 = 1'b1; result8 = 8'd225;
      @(posedge clk); #1;
      res_done8 = 1'b0;
    end
    checks++;
    if (acc_valid8 !== 1'b1 || acc_sum8 !== exp8 || batch_cnt8 !== 3'd0) begin
      errors++;
      $display("FAIL wrap_sum actual v=%b s=%0d c=%0d required v=1 s=%0d c=0",
               acc_valid8, acc_sum8, batch_cnt8, exp8);
    end
  endtask

  initial begin
    test_reset();
    test_batch();
    test_drop();
    test_back_to_back();
    test_clear();
    test_wrap();
    idle(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d required=0 pending sums", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
